memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//   Shares the single multi-cycle main-memory port between the I-cache and D-cache fill
//   controllers. Round-robin arbitration; grant held for a whole block fill. A tag
//   pipeline routes each returning read word to the requester that issued it.
//   Sits between both CacheInterface instances and the memory model.
// PARAMETERS
//   LATENCY  4   memory read latency in cycles (enable-to-valid); >=1
// PORTS
//   clk           in   1   clock, rising edge
//   rst           in   1   asynchronous reset, active-high
//   IReq          in   1   I-cache memory request (held high for entire block fill)
//   IAddr         in   16  I-cache word address
//   DReq          in   1   D-cache memory request (fill or write-through store)
//   DAddr         in   16  D-cache word address
//   DWrite        in   1   D-cache request is a store (write), not a read
//   DWriteData    in   16  D-cache store data
//   MemDataOut    in   16  read data returned by memory
//   MemDataValid  in   1   memory read data valid
//   MemEnable     out  1   memory access enable
//   MemWrite      out  1   memory write strobe
//   MemAddr       out  16  memory address
//   MemDataIn     out  16  memory write data
//   IGrant        out  1   I-cache owns memory port
//   DGrant        out  1   D-cache owns memory port
//   IDataValid    out  1   returned word belongs to I-cache
//   DDataValid    out  1   returned word belongs to D-cache
//   DataOut       out  16  MemDataOut passed through to both caches
// BEHAVIOUR
//   Reset (async, any cycle): state=IDLE, LastOwner=I, grants 0, all tag slots empty;
//     every output 0 except DataOut (=MemDataOut). In-flight reads are discarded.
//   States: IDLE, OWN_I, OWN_D; state and grants are registered.
//   IDLE: IReq&DReq -> owner != LastOwner (first contention after reset goes to D);
//     single request -> that requester; none -> stay IDLE.
//   OWN_x: stay while xReq=1. xReq=0 & other Req=1 -> OWN_other directly (no bubble);
//     xReq=0 & other Req=0 -> IDLE. LastOwner updated to x on every entry to OWN_x.
//   Grant latency: request seen in cycle n -> grant asserted in cycle n+1.
//   IGrant=(state==OWN_I), DGrant=(state==OWN_D); never both high.
//   Memory port (combinational from registered owner):
//     MemEnable = owner's Req; MemAddr = owner's address; MemWrite = DGrant&DReq&DWrite;
//     MemDataIn = DWriteData. In IDLE: MemEnable=MemWrite=0, MemAddr=0, MemDataIn=0.
//   Tag pipeline: LATENCY-deep shift register of {valid, owner}; each cycle shifts one
//     slot; pushes {1,owner} when MemEnable&~MemWrite, else {0,-}.
//   Routing: IDataValid = MemDataValid & head.valid & head.owner==I; D likewise.
//     MemDataValid with empty head -> both valids 0 (stray data dropped).
//   Ownership may switch while reads are in flight; tags keep returning words routed
//     to the original issuer, so the new owner's first word never aliases.
//   Stores: one-cycle write, no tag pushed, no data returned.
//   Fairness: under continuous contention grants alternate per block; no requester
//     waits longer than one full transfer of the other.
// TESTING
//   1. Reset mid-fill: OWN_I, 2 reads in flight, rst pulse -> grants 0, MemEnable 0,
//      later MemDataValid produces no IDataValid/DDataValid.
//   2. IReq alone at cycle 0, IAddr=0x0100..0x0107 -> IGrant cycle 1, MemAddr follows
//      IAddr, IDataValid high LATENCY cycles after each enable, DDataValid stays 0.
//   3. IReq and DReq both rise same cycle after reset -> DGrant first; DReq drops after
//      8 words -> IGrant next cycle with no idle cycle between.
//   4. Handover with in-flight reads: DReq drops while 3 D reads pending, IGrant follows
//      -> next 3 returns raise DDataValid only, then IDataValid for I's first word.
//   5. D store in OWN_D: DWrite=1, DAddr=0x2000, DWriteData=0xBEEF -> MemWrite=1,
//      MemAddr=0x2000, MemDataIn=0xBEEF for one cycle; no valid returned.
//   6. Continuous contention over 4 transfers -> grant order D,I,D,I; both grants never high.

Source files
------------

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//   Shares the single multi-cycle main-memory port between the I-cache and
//   D-cache fill controllers. Round-robin arbitration with the grant held for
//   a whole block fill. A tag pipeline remembers who issued each read so that
//   every returning word is routed to its issuer, even after ownership has
//   moved on.
//
// Parameters
//   LATENCY  memory read latency in cycles (enable-to-valid), >= 1
//   DATA_W   address / data width
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   IReq, IAddr       I-cache request (held for a whole block) and word address
//   DReq, DAddr       D-cache request (fill or store) and word address
//   DWrite            D-cache request is a store
//   DWriteData        D-cache store data
//   MemDataOut        read data from memory
//   MemDataValid      read data valid from memory
//   MemEnable         memory access enable
//   MemWrite          memory write strobe
//   MemAddr           memory address
//   MemDataIn         memory write data
//   IGrant, DGrant    registered ownership of the memory port
//   IDataValid        current returning word belongs to the I-cache
//   DDataValid        current returning word belongs to the D-cache
//   DataOut           MemDataOut passed through to both caches
// ---------------------------------------------------------------------------
module memory_arbiter #(
  parameter int LATENCY = 4,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IReq,
  input  logic [DATA_W-1:0] IAddr,
  input  logic              DReq,
  input  logic [DATA_W-1:0] DAddr,
  input  logic              DWrite,
  input  logic [DATA_W-1:0] DWriteData,
  input  logic [DATA_W-1:0] MemDataOut,
  input  logic              MemDataValid,
  output logic              MemEnable,
  output logic              MemWrite,
  output logic [DATA_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemDataIn,
  output logic              IGrant,
  output logic              DGrant,
  output logic              IDataValid,
  output logic              DDataValid,
  output logic [DATA_W-1:0] DataOut
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_last_d;     // 1: D was the most recent owner
  logic [LATENCY-1:0] r_tag_vld;    // slot LATENCY-1 is the head
  logic [LATENCY-1:0] r_tag_own;    // 1: read was issued by D
  logic               w_push;
  logic               w_push_own;
  logic               w_head_vld;
  logic               w_head_own;

  // Next-state: an owner keeps the port while its request stays high and
  // hands over directly to a waiting requester when it drops.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (IReq && DReq) w_next = r_last_d ? OWN_I : OWN_D;
        else if (IReq)    w_next = OWN_I;
        else if (DReq)    w_next = OWN_D;
        else              w_next = IDLE;
      end
      OWN_I: begin
        if (IReq)      w_next = OWN_I;
        else if (DReq) w_next = OWN_D;
        else           w_next = IDLE;
      end
      OWN_D: begin
        if (DReq)      w_next = OWN_D;
        else if (IReq) w_next = OWN_I;
        else           w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Memory port is driven straight from the registered owner.
  always_comb begin
    MemEnable = 1'b0;
    MemWrite  = 1'b0;
    MemAddr   = '0;
    MemDataIn = '0;
    case (r_state)
      OWN_I: begin
        MemEnable = IReq;
        MemAddr   = IAddr;
        MemDataIn = DWriteData;
      end
      OWN_D: begin
        MemEnable = DReq;
        MemWrite  = DReq & DWrite;
        MemAddr   = DAddr;
        MemDataIn = DWriteData;
      end
      default: ;
    endcase
  end

  // Only reads get a tag; stores return nothing.
  assign w_push     = MemEnable & ~MemWrite;
  assign w_push_own = (r_state == OWN_D);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b0;
      r_tag_vld <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != IDLE) r_last_d <= (w_next == OWN_D);
      for (int i = LATENCY - 1; i > 0; i--) r_tag_vld[i] <= r_tag_vld[i-1];
      r_tag_vld[0] <= w_push;
    end
  end

  // Owner bits only matter when the matching valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = LATENCY - 1; i > 0; i--) r_tag_own[i] <= r_tag_own[i-1];
    r_tag_own[0] <= w_push_own;
  end

  assign w_head_vld = r_tag_vld[LATENCY-1];
  assign w_head_own = r_tag_own[LATENCY-1];

  assign IGrant     = (r_state == OWN_I);
  assign DGrant     = (r_state == OWN_D);
  // Data arriving with an empty head slot is stray and goes to nobody.
  assign IDataValid = MemDataValid & w_head_vld & ~w_head_own;
  assign DDataValid = MemDataValid & w_head_vld &  w_head_own;
  assign DataOut    = MemDataOut;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  localparam int LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        IReq, DReq, DWrite, MemDataValid;
  logic [15:0] IAddr, DAddr, DWriteData, MemDataOut;
  logic        MemEnable, MemWrite, IGrant, DGrant, IDataValid, DDataValid;
  logic [15:0] MemAddr, MemDataIn, DataOut;

  memory_arbiter #(.LATENCY(LATENCY), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .IReq(IReq), .IAddr(IAddr),
    .DReq(DReq), .DAddr(DAddr), .DWrite(DWrite), .DWriteData(DWriteData),
    .MemDataOut(MemDataOut), .MemDataValid(MemDataValid),
    .MemEnable(MemEnable), .MemWrite(MemWrite), .MemAddr(MemAddr), .MemDataIn(MemDataIn),
    .IGrant(IGrant), .DGrant(DGrant),
    .IDataValid(IDataValid), .DDataValid(DDataValid), .DataOut(DataOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        own_d;
    logic [15:0] data;
    int          cyc;     // expected arrival cycle, -1 = any
  } exp_t;

  exp_t       sb[$];
  logic [1:0] glog[$];
  logic [1:0] gprev = 2'b00;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc_n    = 0;

  // requester models
  logic [15:0] i_base, d_base, d_wdata;
  int          i_len, i_blk, i_cnt, d_len, d_blk, d_cnt;
  logic        i_gap = 1'b0, d_gap = 1'b0, d_wr = 1'b0;
  logic        smp_ig, smp_dg;
  logic        stray = 1'b0;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_glog();
    logic [31:0] p = 32'd1;
    foreach (glog[k]) p = (p << 2) | {30'd0, glog[k]};
    return p;
  endfunction

  // cycle counter
  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // memory model: fixed latency, data derived from address
  logic        mv [LATENCY];
  logic [15:0] ma [LATENCY];
  logic        cap_v;
  logic [15:0] cap_a;
  initial begin
    for (int i = 0; i < LATENCY; i++) begin mv[i] = 1'b0; ma[i] = 16'h0; end
    MemDataValid = 1'b0;
    MemDataOut   = 16'hDEAD;
    forever begin
      @(negedge clk);
      cap_v = MemEnable && !MemWrite;
      cap_a = MemAddr;
      @(posedge clk);
      #1;
      for (int i = LATENCY - 1; i > 0; i--) begin mv[i] = mv[i-1]; ma[i] = ma[i-1]; end
      mv[0] = cap_v;
      ma[0] = cap_a;
      MemDataValid = mv[LATENCY-1] | stray;
      MemDataOut   = mv[LATENCY-1] ? mdata(ma[LATENCY-1]) : 16'hDEAD;
    end
  end

  // monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("grant_exclusive", {30'd0, IGrant, DGrant} & 32'h3 & {30'd0, IGrant & DGrant, IGrant & DGrant}, 32'd0);
      if ({IGrant, DGrant} != gprev) begin
        glog.push_back({IGrant, DGrant});
        gprev = {IGrant, DGrant};
      end
      if (IDataValid || DDataValid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got I=%0b D=%0b data=0x%0h expected no valid", IDataValid, DDataValid, DataOut);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("route_owner", {30'd0, IDataValid, DDataValid}, e.own_d ? 32'd1 : 32'd2);
          check("route_data", {16'd0, DataOut}, {16'd0, e.data});
          if (e.cyc >= 0) check("route_latency", cyc_n, e.cyc);
        end
      end
    end
  end

  task automatic start_i(input logic [15:0] base, input int len, input int blk);
    i_base = base; i_len = len; i_blk = blk; i_cnt = 0; i_gap = 1'b0;
    IAddr = base; IReq = 1'b1;
  endtask

  task automatic start_d(input logic [15:0] base, input int len, input int blk,
                         input logic wr, input logic [15:0] wdata);
    d_base = base; d_len = len; d_blk = blk; d_cnt = 0; d_gap = 1'b0; d_wr = wr;
    DAddr = base; DWrite = wr; DWriteData = wdata; d_wdata = wdata; DReq = 1'b1;
  endtask

  task automatic push_blk(input logic own_d, input logic [15:0] base, input int len);
    for (int k = 0; k < len; k++) begin
      exp_t e;
      e.own_d = own_d; e.data = mdata(16'(base + k)); e.cyc = -1;
      sb.push_back(e);
    end
  endtask

  // one clock of both requester models
  task automatic cyc();
    logic ii, di;
    @(negedge clk);
    ii = IGrant && IReq;
    di = DGrant && DReq;
    smp_ig = IGrant;
    smp_dg = DGrant;
    if (ii) check("i_mem_addr", {16'd0, MemAddr}, {16'd0, 16'(i_base + i_cnt)});
    if (di) begin
      check("d_mem_addr", {16'd0, MemAddr}, {16'd0, 16'(d_base + d_cnt)});
      check("d_mem_write", {31'd0, MemWrite}, {31'd0, d_wr});
      if (d_wr) check("d_mem_wdata", {16'd0, MemDataIn}, {16'd0, d_wdata});
    end
    @(posedge clk);
    #1;
    if (ii) begin
      i_cnt++;
      if (i_cnt == i_len) begin
        IReq = 1'b0; i_cnt = 0; i_base = 16'(i_base + 16); i_blk--; i_gap = (i_blk > 0);
      end
    end else if (i_gap) begin
      IReq = 1'b1; i_gap = 1'b0;
    end
    IAddr = 16'(i_base + i_cnt);
    if (di) begin
      d_cnt++;
      if (d_cnt == d_len) begin
        DReq = 1'b0; d_cnt = 0; d_base = 16'(d_base + 16); d_blk--; d_gap = (d_blk > 0);
      end
    end else if (d_gap) begin
      DReq = 1'b1; d_gap = 1'b0;
    end
    DAddr = 16'(d_base + d_cnt);
  endtask

  task automatic wait_idle(input string name);
    int budget = 300;
    while ((IReq || DReq || i_gap || d_gap) && budget > 0) begin
      cyc();
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got requests still pending expected completion", name);
      IReq = 1'b0; DReq = 1'b0; i_gap = 1'b0; d_gap = 1'b0;
    end
    repeat (LATENCY + 3) cyc();
    check({name, "_drain"}, sb.size(), 0);
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    glog.delete();
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    IReq = 1'b0; DReq = 1'b0; DWrite = 1'b0;
    IAddr = 16'h0; DAddr = 16'h0; DWriteData = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {24'd0, IGrant, DGrant, MemEnable, MemWrite, IDataValid, DDataValid, |MemAddr, |MemDataIn}, 32'd0);
    check("reset_dataout", {16'd0, DataOut}, 32'h0000DEAD);
    rst = 1'b0;

    // 1: reset during an I fill with two reads in flight
    @(posedge clk); #1;
    start_i(16'h0100, 8, 1);
    repeat (3) cyc();
    #2;
    rst = 1'b1;
    IReq = 1'b0; i_gap = 1'b0;
    #1;
    check("t1_async_reset", {29'd0, IGrant, DGrant, MemEnable}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (LATENCY + 3) cyc();
    check("t1_idle_after", {29'd0, IGrant, DGrant, MemEnable}, 32'd0);
    glog.delete();

    // 2: lone I block, grant one cycle after request, exact return latency
    @(posedge clk); #1;
    start_i(16'h0100, 8, 1);
    c0 = cyc_n;
    for (int k = 0; k < 8; k++) begin
      exp_t e;
      e.own_d = 1'b0; e.data = mdata(16'(16'h0100 + k)); e.cyc = c0 + 1 + k + LATENCY;
      sb.push_back(e);
    end
    @(negedge clk);
    check("t2_grant_c0", {31'd0, IGrant}, 32'd0);
    cyc();
    check("t2_grant_c1", {31'd0, smp_ig}, 32'd1);
    wait_idle("t2");
    check("t2_grant_log", pack_glog(), 32'h18);

    // 3: simultaneous requests after reset -> D first, then I with no bubble
    pulse_rst();
    start_i(16'h0200, 8, 1);
    start_d(16'h3000, 8, 1, 1'b0, 16'h0000);
    push_blk(1'b1, 16'h3000, 8);
    push_blk(1'b0, 16'h0200, 8);
    wait_idle("t3");
    check("t3_grant_log", pack_glog(), 32'h58);

    // 4: handover while D reads are still in flight
    glog.delete();
    start_i(16'h0300, 2, 1);
    start_d(16'h3100, 3, 1, 1'b0, 16'h0000);
    push_blk(1'b1, 16'h3100, 3);
    push_blk(1'b0, 16'h0300, 2);
    wait_idle("t4");
    check("t4_grant_log", pack_glog(), 32'h58);

    // 5: single D store, then stray memory valids must be dropped
    start_d(16'h2000, 1, 1, 1'b1, 16'hBEEF);
    @(negedge clk);
    cyc();
    check("t5_store_granted", {31'd0, smp_dg}, 32'd1);
    @(negedge clk);
    check("t5_write_one_cycle", {31'd0, MemWrite}, 32'd0);
    d_wr = 1'b0; DWrite = 1'b0;
    @(posedge clk); #1;
    stray = 1'b1;
    repeat (LATENCY + 2) begin
      @(negedge clk);
      check("t5_dataout_pass", {16'd0, DataOut}, {16'd0, MemDataOut});
    end
    @(posedge clk); #1;
    stray = 1'b0;
    repeat (2) cyc();
    check("t5_drain", sb.size(), 0);

    // 6: continuous contention over four transfers -> D,I,D,I
    pulse_rst();
    start_i(16'h0400, 4, 2);
    start_d(16'h4000, 4, 2, 1'b0, 16'h0000);
    push_blk(1'b1, 16'h4000, 4);
    push_blk(1'b0, 16'h0400, 4);
    push_blk(1'b1, 16'h4010, 4);
    push_blk(1'b0, 16'h0410, 4);
    wait_idle("t6");
    check("t6_grant_log", pack_glog(), 32'h598);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
